// File: rtl/lumi_link_scheduler.sv
// -----------------------------------------------------------------------------
// lumi_link_scheduler
//
// Frames luminosity payloads from N_REQ requesters onto the single 16-bit
// parallel word feeding the lumi DDR serializer. Exactly one word leaves per
// clk_par cycle: idle filler, sync, header, payload, trailer (and CRC when
// enabled). Requesters are granted round-robin, one per frame, and a sync
// word is inserted periodically between frames to keep the deserializer
// aligned.
//
// Ports
//   clk_par    in   parallel-word clock
//   reset_n    in   synchronous, active-low reset
//   enable     in   gates the start of new frames only
//   req_valid  in   [N_REQ]     requester has a payload word
//   req_data   in   [16*N_REQ]  payload words, requester i at [16i+15:16i]
//   req_last   in   [N_REQ]     current word ends the requester's packet
//   req_ready  out  [N_REQ]     word accepted this cycle (combinational)
//   par_word   out  [16]        registered word to the serializer
//   par_ctrl   out  1           registered, high for every non-payload word
//   frame_seq  out  [8]         sequence number of the last header sent
//
// Build option
//   LUMI_SCHED_CRC_EN  when defined, every trailer is followed by a
//                      CRC-16-CCITT word (poly 0x1021, init 0xFFFF) covering
//                      the accepted payload words of the frame.
// -----------------------------------------------------------------------------
module lumi_link_scheduler #(
    parameter int          N_REQ       = 4,
    parameter int          MAX_LEN     = 16,
    parameter int          SYNC_PERIOD = 64,
    parameter logic [15:0] IDLE_WORD   = 16'hBC50,
    parameter logic [15:0] SYNC_WORD   = 16'hBC3C
) (
    input  logic                 clk_par,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [15:0]          par_word,
    output logic                 par_ctrl,
    output logic [7:0]           frame_seq
);

    localparam int SCW = $clog2(SYNC_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_HEADER,
        S_PAYLOAD,
        S_TRAILER
`ifdef LUMI_SCHED_CRC_EN
        , S_CRC
`endif
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [2:0]      grant;
    logic [2:0]      rr_ptr;
    logic [7:0]      seq;
    logic [7:0]      len;
    logic [7:0]      len_inc;
    logic [SCW-1:0]  sync_cnt;
    logic            sync_due;
    logic [2:0]      pick;
    logic            found;
    logic            g_valid;
    logic            g_last;
    logic [15:0]     g_data;
    logic            accept;
    logic [15:0]     word_d;
    logic            ctrl_d;

`ifdef LUMI_SCHED_CRC_EN
    logic [15:0]     crc;

    // One CRC-16-CCITT step over a 16-bit word, MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 15; b >= 0; b--) begin
            fb = r[15] ^ d[b];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction
`endif

    assign sync_due = (sync_cnt >= SCW'(SYNC_PERIOD - 1));
    assign len_inc  = len + 8'd1;

    // Round-robin pick: first valid requester at or above rr_ptr, otherwise
    // wrap around to the lowest-numbered valid requester.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && (3'(i) >= rr_ptr)) begin
                pick  = 3'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                pick  = 3'(i);
                found = 1'b1;
            end
        end
    end

    // Select the granted requester's handshake signals and raise its ready
    // only while payload is being transferred.
    always_comb begin
        g_valid   = 1'b0;
        g_last    = 1'b0;
        g_data    = '0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == 3'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[16*i +: 16];
            end
            if (state == S_PAYLOAD) req_ready[i] = (grant == 3'(i));
        end
    end

    // Next-state and next-output decode. The word computed here is
    // registered, so a state's word appears one cycle after that state.
    always_comb begin
        next_state = state;
        word_d     = IDLE_WORD;
        ctrl_d     = 1'b1;
        accept     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (sync_due)              next_state = S_SYNC;
                else if (enable && found)  next_state = S_HEADER;
            end
            S_SYNC: begin
                word_d     = SYNC_WORD;
                next_state = S_IDLE;
            end
            S_HEADER: begin
                word_d     = {4'hA, 1'b0, grant, seq};
                next_state = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                // A stalled requester yields the idle filler with ctrl high.
                if (g_valid) begin
                    accept = 1'b1;
                    word_d = g_data;
                    ctrl_d = 1'b0;
                    if (g_last || (len_inc == 8'(MAX_LEN))) next_state = S_TRAILER;
                end
            end
            S_TRAILER: begin
                word_d = {4'hE, 1'b0, grant, len};
`ifdef LUMI_SCHED_CRC_EN
                next_state = S_CRC;
`else
                next_state = S_IDLE;
`endif
            end
`ifdef LUMI_SCHED_CRC_EN
            S_CRC: begin
                word_d     = crc;
                next_state = S_IDLE;
            end
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // State, output and bookkeeping registers. Reset lands in SYNC so the
    // first word after release realigns the deserializer.
    always_ff @(posedge clk_par) begin
        if (!reset_n) begin
            state     <= S_SYNC;
            par_word  <= IDLE_WORD;
            par_ctrl  <= 1'b1;
            grant     <= '0;
            rr_ptr    <= '0;
            seq       <= '0;
            frame_seq <= '0;
            len       <= '0;
            sync_cnt  <= '0;
        end else begin
            state    <= next_state;
            par_word <= word_d;
            par_ctrl <= ctrl_d;
            if (state == S_SYNC)  sync_cnt <= '0;
            else if (!sync_due)   sync_cnt <= sync_cnt + SCW'(1);
            if (state == S_IDLE && next_state == S_HEADER) grant <= pick;
            if (state == S_HEADER) begin
                frame_seq <= seq;
                seq       <= seq + 8'd1;
            end
            if (accept) len <= len_inc;
            if (state == S_TRAILER) begin
                rr_ptr <= (grant == 3'(N_REQ - 1)) ? 3'd0 : grant + 3'd1;
                len    <= '0;
            end
        end
    end

`ifdef LUMI_SCHED_CRC_EN
    // Frame CRC restarts at each header and absorbs accepted payload only.
    always_ff @(posedge clk_par) begin
        if (!reset_n)                crc <= 16'hFFFF;
        else if (state == S_HEADER)  crc <= 16'hFFFF;
        else if (accept)             crc <= crc16_step(crc, g_data);
    end
`endif

endmodule

// File: tb/tb_lumi_link_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lumi_link_scheduler
//
// Scoreboard bench for lumi_link_scheduler. Stimulus pushes each payload word
// into a per-requester driver queue and an identical expected queue. A
// monitor parses the output word stream at every falling edge and checks it
// against framing rules: sync spacing, round-robin grant choice from the
// sampled request vector, header/trailer formats, sequence numbers, payload
// order, MAX_LEN splitting and (with LUMI_SCHED_CRC_EN) the frame CRC.
// -----------------------------------------------------------------------------
module tb_lumi_link_scheduler;

    localparam int          N_REQ       = 4;
    localparam int          MAX_LEN     = 16;
    localparam int          SYNC_PERIOD = 64;
    localparam logic [15:0] IDLE_WORD   = 16'hBC50;
    localparam logic [15:0] SYNC_WORD   = 16'hBC3C;

    localparam int M_OUT     = 0;
    localparam int M_PAYLOAD = 1;
    localparam int M_TRAILER = 2;
    localparam int M_CRC     = 3;

    logic                clk_par = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable  = 1'b0;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [16*N_REQ-1:0] req_data  = '0;
    logic [N_REQ-1:0]    req_last  = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [15:0]         par_word;
    logic                par_ctrl;
    logic [7:0]          frame_seq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] drv_q [N_REQ][$];
    logic [16:0] exp_q [N_REQ][$];
    int          valid_pct   = 100;
    bit          rand_enable = 1'b0;

    int          mon_mode  = M_OUT;
    int          mon_cnt   = 0;

    lumi_link_scheduler #(
        .N_REQ(N_REQ), .MAX_LEN(MAX_LEN), .SYNC_PERIOD(SYNC_PERIOD),
        .IDLE_WORD(IDLE_WORD), .SYNC_WORD(SYNC_WORD)
    ) dut (
        .clk_par(clk_par), .reset_n(reset_n), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .par_word(par_word), .par_ctrl(par_ctrl),
        .frame_seq(frame_seq)
    );

    always #5 clk_par = ~clk_par;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

`ifdef LUMI_SCHED_CRC_EN
    function automatic logic [15:0] crcWord(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 15; b >= 0; b--) begin
            fb = r[15] ^ d[b];
            r  = r << 1;
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction
`endif

    function automatic int rrFirst(input logic [N_REQ-1:0] v, input int start);
        for (int k = 0; k < N_REQ; k++)
            if (v[(start + k) % N_REQ]) return (start + k) % N_REQ;
        return -1;
    endfunction

    function automatic bit allEmpty();
        for (int i = 0; i < N_REQ; i++)
            if (drv_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pushWord(input int r, input logic [15:0] d, input logic last);
        drv_q[r].push_back({last, d});
        exp_q[r].push_back({last, d});
    endtask

    // One driver cycle: retire words handshaken on the last edge, then
    // present the next word (or junk with valid low) for every requester.
    task automatic applyStimulus();
        logic [N_REQ-1:0] hs;
        @(negedge clk_par);
        hs = req_valid & req_ready;
        @(posedge clk_par);
        #1;
        for (int i = 0; i < N_REQ; i++)
            if (hs[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        for (int i = 0; i < N_REQ; i++) begin
            if (drv_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                req_valid[i]        = 1'b1;
                req_data[16*i +: 16] = drv_q[i][0][15:0];
                req_last[i]         = drv_q[i][0][16];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[16*i +: 16] = 16'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
        if (rand_enable) enable = ($urandom_range(99) < 85);
    endtask

    task automatic waitDrain(input int budget);
        int c;
        int left;
        c = 0;
        while (c < budget && !(allEmpty() && mon_mode == M_OUT)) begin
            @(posedge clk_par);
            c++;
        end
        checkOutput("drain within budget", 32'(c < budget), 1);
        left = 0;
        for (int i = 0; i < N_REQ; i++) left += exp_q[i].size();
        checkOutput("no expected words left", 32'(left), 0);
    endtask

    initial begin : driver
        forever applyStimulus();
    end

    // Monitor: classifies each output word and checks it against the rules.
    initial begin : monitor
        logic [16:0]      act;
        logic [16:0]      e;
        logic [N_REQ-1:0] cur_v, v1, v2;
        logic             cur_en, en1, en2;
        int               cyc, last_sync, rst_low, g, ch, rr;
        logic [7:0]       exp_seq;
        bit               after_rst, expect_sync, prev_idle, now_idle;
        logic [15:0]      crc;
        cyc = 0; last_sync = 0; rst_low = 0; g = 0; rr = 0; exp_seq = 0;
        after_rst = 1'b0; expect_sync = 1'b0; prev_idle = 1'b0;
        v1 = '0; v2 = '0; en1 = 1'b0; en2 = 1'b0; crc = 16'hFFFF;
        forever begin
            @(negedge clk_par);
            cyc++;
            cur_v    = req_valid;
            cur_en   = enable;
            act      = {par_ctrl, par_word};
            now_idle = 1'b0;
            if (!reset_n) begin
                rst_low++;
                if (rst_low >= 2) begin
                    checkOutput("reset word", 32'(act), 32'({1'b1, IDLE_WORD}));
                    checkOutput("reset req_ready", 32'(req_ready), 0);
                    checkOutput("reset frame_seq", 32'(frame_seq), 0);
                end
                mon_mode = M_OUT; exp_seq = 8'd0; rr = 0; after_rst = 1'b1;
            end else if (after_rst) begin
                rst_low = 0; after_rst = 1'b0; expect_sync = 1'b1;
                checkOutput("word at reset release", 32'(act), 32'({1'b1, IDLE_WORD}));
                checkOutput("ready at reset release", 32'(req_ready), 0);
            end else begin
                checkOutput("req_ready onehot0", 32'($onehot0(req_ready)), 1);
                case (mon_mode)
                    M_OUT: begin
                        if (expect_sync || (prev_idle && (cyc - 1 >= last_sync + SYNC_PERIOD))) begin
                            checkOutput("sync word", 32'(act), 32'({1'b1, SYNC_WORD}));
                            last_sync = cyc; expect_sync = 1'b0;
                        end else if (prev_idle && en2 && (v2 != '0)) begin
                            ch = rrFirst(v2, rr);
                            checkOutput("header", 32'(act), 32'({1'b1, 4'hA, 1'b0, 3'(ch), exp_seq}));
                            checkOutput("frame_seq", 32'(frame_seq), 32'(exp_seq));
                            g = ch; exp_seq = exp_seq + 8'd1;
                            mon_mode = M_PAYLOAD; mon_cnt = 0; crc = 16'hFFFF;
                        end else begin
                            checkOutput("idle word", 32'(act), 32'({1'b1, IDLE_WORD}));
                            now_idle = 1'b1;
                        end
                    end
                    M_PAYLOAD: begin
                        if (par_ctrl) begin
                            checkOutput("stall filler", 32'(par_word), 32'(IDLE_WORD));
                        end else if (exp_q[g].size() == 0) begin
                            checkOutput("payload with nothing queued", 32'(par_word), 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q[g].pop_front();
                            checkOutput("payload word", 32'(par_word), 32'(e[15:0]));
                            mon_cnt++;
`ifdef LUMI_SCHED_CRC_EN
                            crc = crcWord(crc, e[15:0]);
`endif
                            if (e[16] || mon_cnt == MAX_LEN) mon_mode = M_TRAILER;
                        end
                    end
                    M_TRAILER: begin
                        checkOutput("trailer", 32'(act), 32'({1'b1, 4'hE, 1'b0, 3'(g), 8'(mon_cnt)}));
                        rr = (g + 1) % N_REQ;
`ifdef LUMI_SCHED_CRC_EN
                        mon_mode = M_CRC;
`else
                        mon_mode = M_OUT;
`endif
                    end
                    default: begin
                        checkOutput("crc word", 32'(act), 32'({1'b1, crc}));
                        mon_mode = M_OUT;
                    end
                endcase
            end
            prev_idle = now_idle;
            v2 = v1; en2 = en1; v1 = cur_v; en1 = cur_en;
        end
    end

    initial begin : watchdog
        #800000;
        n_fail++;
        $display("[TB] FAIL watchdog: time limit reached before the end of the test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        int r;
        int l;
        int c;
        reset_n = 1'b0;
        repeat (3) @(posedge clk_par);
        #2 reset_n = 1'b1;
        enable = 1'b1;

        $display("[TB] idle stream with periodic sync");
        repeat (150) @(posedge clk_par);

        $display("[TB] requester 2 three-word packet");
        pushWord(2, 16'h1111, 1'b0);
        pushWord(2, 16'h2222, 1'b0);
        pushWord(2, 16'h3333, 1'b1);
        waitDrain(2000);

`ifdef LUMI_SCHED_CRC_EN
        $display("[TB] single zero payload word with CRC");
        pushWord(1, 16'h0000, 1'b1);
        waitDrain(2000);
`endif

        $display("[TB] requester 0 twenty-word packet split at MAX_LEN");
        for (int k = 0; k < 20; k++) pushWord(0, 16'h0100 + 16'(k), (k == 19));
        waitDrain(2000);

        $display("[TB] all requesters valid with one-word packets");
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < N_REQ; i++)
                pushWord(i, 16'hC000 | 16'(i << 4) | 16'(rep), 1'b1);
        waitDrain(2000);

        $display("[TB] random packets with stalls and enable toggling");
        valid_pct   = 70;
        rand_enable = 1'b1;
        for (int p = 0; p < 40; p++) begin
            r = int'($urandom_range(N_REQ - 1));
            l = int'($urandom_range(24, 1));
            for (int k = 0; k < l; k++) pushWord(r, 16'($urandom), (k == l - 1));
        end
        waitDrain(20000);
        rand_enable = 1'b0;
        valid_pct   = 100;
        enable      = 1'b1;

        $display("[TB] reset in the middle of a frame");
        for (int k = 0; k < 12; k++) pushWord(1, 16'h5A00 + 16'(k), (k == 11));
        c = 0;
        while (c < 500 && !(mon_mode == M_PAYLOAD && mon_cnt >= 3)) begin
            @(posedge clk_par);
            c++;
        end
        checkOutput("reached mid-frame", 32'(c < 500), 1);
        @(posedge clk_par);
        #2 reset_n = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
        end
        req_valid = '0;
        repeat (3) @(posedge clk_par);
        #2 reset_n = 1'b1;
        repeat (80) @(posedge clk_par);

        $display("[TB] first frame after reset");
        pushWord(3, 16'h7777, 1'b1);
        waitDrain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
